// File: rtl/alu_arbiter.sv
// Two-requester front end that time-shares one external ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP. RR_EN selects round-robin (1) or fixed priority (0).
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        rsp1_err,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MAX = 4'b1001;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q;
  logic        lastGrant_q;
  logic        grantIdx_q;
  logic        postReset_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        err_q;
  logic        valid0_q;
  logic        valid1_q;

  logic        grant_d;
  logic        acceptOpen;
  logic        transfer;
  logic        rspReadySel;
  logic        opSupported;
  logic        inExec;

  // On a tie, round-robin hands the slot to whoever did not win last time.
  always_comb begin
    grant_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = RR_EN ? ~lastGrant_q : 1'b0;
    end else if (req1_valid) begin
      grant_d = 1'b1;
    end
  end

  // Readiness is a function of state and requests only, never of the response handshake.
  assign acceptOpen  = (state_q == IDLE) && !rst && !postReset_q;
  assign req0_ready  = acceptOpen && req0_valid && !grant_d;
  assign req1_ready  = acceptOpen && req1_valid && grant_d;
  assign transfer    = req0_ready || req1_ready;

  assign inExec      = (state_q == EXEC);
  assign alu_op      = inExec ? op_q : OP_ADD;
  assign alu_a       = inExec ? a_q : 32'd0;
  assign alu_b       = inExec ? b_q : 32'd0;
  assign opSupported = (op_q <= OP_MAX);

  assign rspReadySel = grantIdx_q ? rsp1_ready : rsp0_ready;

  assign rsp0_valid  = valid0_q;
  assign rsp1_valid  = valid1_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      grantIdx_q  <= 1'b0;
      postReset_q <= 1'b1;
      op_q        <= 4'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      result_q    <= 32'd0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
    end else begin
      postReset_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (transfer) begin
            op_q        <= grant_d ? req1_op : req0_op;
            a_q         <= grant_d ? req1_a : req0_a;
            b_q         <= grant_d ? req1_b : req0_b;
            grantIdx_q  <= grant_d;
            lastGrant_q <= grant_d;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported codes never see the ALU result; they report a flagged zero.
          result_q <= opSupported ? alu_out : 32'd0;
          zero_q   <= opSupported ? alu_zero : 1'b1;
          err_q    <= !opSupported;
          valid0_q <= !grantIdx_q;
          valid1_q <= grantIdx_q;
          state_q  <= RESP;
        end
        RESP: begin
          if (rspReadySel) begin
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          valid0_q <= 1'b0;
          valid1_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Drives a round-robin and a fixed-priority alu_arbiter with the same stimulus, each backed by its
// own bench ALU, and compares both against a transaction-level reference plus literal expectations.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_ready, rsp1_ready;

  logic        dRdy0[2], dRdy1[2], dRspV0[2], dRspV1[2];
  logic [31:0] dRes0[2], dRes1[2];
  logic        dZ0[2], dZ1[2], dE0[2], dE1[2];
  logic [3:0]  dAluOp[2];
  logic [31:0] dAluA[2], dAluB[2];
  logic [31:0] aluOut[2];
  logic        aluZero[2];

  int checks = 0;
  int errors = 0;

  int          mPhase[2];
  logic        mHold[2], mLast[2], mIdx[2];
  logic [3:0]  mOp[2];
  logic [31:0] mA[2], mB[2];
  logic        modelOn = 1'b0;
  logic        mG, mOpen, mE0, mE1, mSup;
  logic [31:0] mRes;

  typedef struct {
    bit          r;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  // Reference ALU; unsupported codes return garbage so a leaked alu_out is visible.
  function automatic logic [31:0] aluFn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return ~(a | b);
      4'b0101: return a << b[4:0];
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return a >> b[4:0];
      4'b1001: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      aluOut[k]  = aluFn(dAluOp[k], dAluA[k], dAluB[k]);
      aluZero[k] = (aluOut[k] == 32'd0);
    end
  end

  alu_arbiter #(.RR_EN(1'b1)) dutRr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(dRdy0[0]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(dRdy1[0]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(dRspV0[0]), .rsp0_ready(rsp0_ready), .rsp0_result(dRes0[0]), .rsp0_zero(dZ0[0]), .rsp0_err(dE0[0]),
    .rsp1_valid(dRspV1[0]), .rsp1_ready(rsp1_ready), .rsp1_result(dRes1[0]), .rsp1_zero(dZ1[0]), .rsp1_err(dE1[0]),
    .alu_op(dAluOp[0]), .alu_a(dAluA[0]), .alu_b(dAluB[0]), .alu_out(aluOut[0]), .alu_zero(aluZero[0])
  );

  alu_arbiter #(.RR_EN(1'b0)) dutFp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(dRdy0[1]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(dRdy1[1]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(dRspV0[1]), .rsp0_ready(rsp0_ready), .rsp0_result(dRes0[1]), .rsp0_zero(dZ0[1]), .rsp0_err(dE0[1]),
    .rsp1_valid(dRspV1[1]), .rsp1_ready(rsp1_ready), .rsp1_result(dRes1[1]), .rsp1_zero(dZ1[1]), .rsp1_err(dE1[1]),
    .alu_op(dAluOp[1]), .alu_a(dAluA[1]), .alu_b(dAluB[1]), .alu_out(aluOut[1]), .alu_zero(aluZero[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleReqs();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // Transaction-level reference: one accepted op occupies the block for accept, execute and
  // at least one response cycle; readiness is closed during reset and the cycle after it.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        mG    = (req0_valid && req1_valid) ? ((k == 0) ? !mLast[k] : 1'b0) : req1_valid;
        mOpen = !rst && !mHold[k] && (mPhase[k] == 0);
        mE0   = mOpen && req0_valid && !mG;
        mE1   = mOpen && req1_valid && mG;
        if (modelOn) begin
          checkOutput($sformatf("dut%0d req0_ready", k), 32'(dRdy0[k]), 32'(mE0));
          checkOutput($sformatf("dut%0d req1_ready", k), 32'(dRdy1[k]), 32'(mE1));
          checkOutput($sformatf("dut%0d rsp0_valid", k), 32'(dRspV0[k]), 32'(mPhase[k] == 2 && !mIdx[k]));
          checkOutput($sformatf("dut%0d rsp1_valid", k), 32'(dRspV1[k]), 32'(mPhase[k] == 2 && mIdx[k]));
          if (mPhase[k] == 2) begin
            mSup = (mOp[k] <= 4'd9);
            mRes = mSup ? aluFn(mOp[k], mA[k], mB[k]) : 32'd0;
            if (!mIdx[k]) begin
              checkOutput($sformatf("dut%0d rsp0_result", k), dRes0[k], mRes);
              checkOutput($sformatf("dut%0d rsp0_zero", k), 32'(dZ0[k]), 32'(mRes == 32'd0));
              checkOutput($sformatf("dut%0d rsp0_err", k), 32'(dE0[k]), 32'(!mSup));
            end else begin
              checkOutput($sformatf("dut%0d rsp1_result", k), dRes1[k], mRes);
              checkOutput($sformatf("dut%0d rsp1_zero", k), 32'(dZ1[k]), 32'(mRes == 32'd0));
              checkOutput($sformatf("dut%0d rsp1_err", k), 32'(dE1[k]), 32'(!mSup));
            end
          end
          checkOutput($sformatf("dut%0d alu_op", k), 32'(dAluOp[k]), (mPhase[k] == 1) ? 32'(mOp[k]) : 32'd2);
          checkOutput($sformatf("dut%0d alu_a", k), dAluA[k], (mPhase[k] == 1) ? mA[k] : 32'd0);
          checkOutput($sformatf("dut%0d alu_b", k), dAluB[k], (mPhase[k] == 1) ? mB[k] : 32'd0);
        end
        if (rst) begin
          mPhase[k] = 0;
          mHold[k]  = 1'b1;
          mLast[k]  = 1'b1;
          mIdx[k]   = 1'b0;
        end else if (modelOn) begin
          mHold[k] = 1'b0;
          case (mPhase[k])
            0: if (mE0 || mE1) begin
              mIdx[k]   = mE1;
              mLast[k]  = mE1;
              mOp[k]    = mE1 ? req1_op : req0_op;
              mA[k]     = mE1 ? req1_a : req0_a;
              mB[k]     = mE1 ? req1_b : req0_b;
              mPhase[k] = 1;
            end
            1: mPhase[k] = 2;
            default: if (mIdx[k] ? rsp1_ready : rsp0_ready) mPhase[k] = 0;
          endcase
        end
      end
      if (rst) modelOn = 1'b1;
    end
  end

  initial begin
    #50000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int rrOrder[4];
    int rrCount;
    int fpReq0;
    int fpReq1;

    vecs[0] = '{1'b0, 4'b0000, 32'hF0F0_0000, 32'hFF00_FF00, 32'hF000_0000};
    vecs[1] = '{1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0};
    vecs[2] = '{1'b0, 4'b0011, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA};
    vecs[3] = '{1'b1, 4'b0100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 4'b0101, 32'h0000_0001, 32'd31,        32'h8000_0000};
    vecs[5] = '{1'b1, 4'b1000, 32'h8000_0000, 32'd31,        32'h0000_0001};
    vecs[6] = '{1'b0, 4'b0110, 32'd5,         32'd5,         32'h0000_0000};
    vecs[7] = '{1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd0,         32'h0000_0001};

    // Reset with a request already pending; it must not be accepted yet.
    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(1'b1, 4'b0010, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("reset req0_ready", 32'(dRdy0[0]), 32'd0);
    checkOutput("reset rsp0_valid", 32'(dRspV0[0]), 32'd0);
    checkOutput("reset rsp1_valid", 32'(dRspV1[0]), 32'd0);
    checkOutput("reset rsp0_err", 32'(dE0[0]), 32'd0);
    checkOutput("reset result", dRes0[0], 32'd0);
    checkOutput("reset alu_op", 32'(dAluOp[0]), 32'd2);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset req0_ready", 32'(dRdy0[0]), 32'd0);

    // Single ADD request: accept, execute, respond.
    nextCycle();
    @(negedge clk);
    checkOutput("add req0_ready", 32'(dRdy0[0]), 32'd1);
    nextCycle();
    idleReqs();
    @(negedge clk);
    checkOutput("add exec alu_op", 32'(dAluOp[0]), 32'd2);
    checkOutput("add exec alu_a", dAluA[0], 32'd5);
    checkOutput("add exec alu_b", dAluB[0], 32'd7);
    nextCycle();
    @(negedge clk);
    checkOutput("add rsp0_valid", 32'(dRspV0[0]), 32'd1);
    checkOutput("add rsp0_result", dRes0[0], 32'd12);
    checkOutput("add rsp0_zero", 32'(dZ0[0]), 32'd0);
    checkOutput("add rsp0_err", 32'(dE0[0]), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("add rsp0_valid drop", 32'(dRspV0[0]), 32'd0);

    // Continuous tie from a fresh reset.
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0110, 32'd9, 32'd9, 1'b1, 4'b0111, 32'd3, 32'd4);
    nextCycle();
    rst = 1'b0;
    rrOrder = '{9, 9, 9, 9};
    rrCount = 0;
    fpReq0  = 0;
    fpReq1  = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (dRdy0[0] && rrCount < 4) begin rrOrder[rrCount] = 0; rrCount++; end
      if (dRdy1[0] && rrCount < 4) begin rrOrder[rrCount] = 1; rrCount++; end
      if (dRdy0[1]) fpReq0++;
      if (dRdy1[1]) fpReq1++;
      if (dRspV0[0]) begin
        checkOutput("tie rr rsp0_result", dRes0[0], 32'd0);
        checkOutput("tie rr rsp0_zero", 32'(dZ0[0]), 32'd1);
      end
      if (dRspV1[0]) begin
        checkOutput("tie rr rsp1_result", dRes1[0], 32'd1);
        checkOutput("tie rr rsp1_zero", 32'(dZ1[0]), 32'd0);
      end
      nextCycle();
    end
    idleReqs();
    for (int n = 0; n < 4; n++) begin
      checkOutput($sformatf("tie rr grant %0d", n), 32'(rrOrder[n]), 32'(n % 2));
    end
    checkOutput("tie fp req0 grants", 32'(fpReq0), 32'd4);
    checkOutput("tie fp req1 grants", 32'(fpReq1), 32'd0);
    @(negedge clk);
    nextCycle();

    // Assorted single operations alternating between requesters.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(!vecs[v].r, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].r, vecs[v].op, vecs[v].a, vecs[v].b);
      @(negedge clk);
      nextCycle();
      idleReqs();
      @(negedge clk);
      nextCycle();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("vec%0d dut%0d valid", v, k), 32'(vecs[v].r ? dRspV1[k] : dRspV0[k]), 32'd1);
        checkOutput($sformatf("vec%0d dut%0d result", v, k), vecs[v].r ? dRes1[k] : dRes0[k], vecs[v].exp);
      end
      nextCycle();
    end

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b1001, 32'h8000_0000, 32'd4);
    @(negedge clk);
    checkOutput("bp req1_ready", 32'(dRdy1[0]), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 4'b0000, 32'h0000_00F0, 32'h0000_003C, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("bp exec req0_ready", 32'(dRdy0[0]), 32'd0);
    nextCycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp hold%0d rsp1_valid", c), 32'(dRspV1[0]), 32'd1);
      checkOutput($sformatf("bp hold%0d rsp1_result", c), dRes1[0], 32'hF800_0000);
      checkOutput($sformatf("bp hold%0d req0_ready", c), 32'(dRdy0[0]), 32'd0);
      nextCycle();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release rsp1_valid", 32'(dRspV1[0]), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("bp idle rsp1_valid", 32'(dRspV1[0]), 32'd0);
    checkOutput("bp idle req0_ready", 32'(dRdy0[0]), 32'd1);
    nextCycle();
    idleReqs();
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checkOutput("bp follow-on result", dRes0[0], 32'h0000_0030);
    nextCycle();

    // Unsupported op code.
    applyStimulus(1'b1, 4'b1111, 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    nextCycle();
    idleReqs();
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checkOutput("illegal rsp0_valid", 32'(dRspV0[0]), 32'd1);
    checkOutput("illegal rsp0_result", dRes0[0], 32'd0);
    checkOutput("illegal rsp0_zero", 32'(dZ0[0]), 32'd1);
    checkOutput("illegal rsp0_err", 32'(dE0[0]), 32'd1);
    nextCycle();

    // Reset while an operation is executing; the operation vanishes.
    applyStimulus(1'b1, 4'b0010, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    nextCycle();
    idleReqs();
    rst = 1'b1;
    @(negedge clk);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 4'b0110, 32'd9, 32'd9, 1'b1, 4'b0111, 32'd3, 32'd4);
    @(negedge clk);
    checkOutput("midrst rsp0_valid", 32'(dRspV0[0]), 32'd0);
    checkOutput("midrst rsp1_valid", 32'(dRspV1[0]), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("midrst tie req0_ready", 32'(dRdy0[0]), 32'd1);
    checkOutput("midrst tie req1_ready", 32'(dRdy1[0]), 32'd0);
    nextCycle();
    idleReqs();
    repeat (3) begin
      @(negedge clk);
      nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
